// File: rtl/dlx_cu_pkg.sv
// DLX pipelined control unit: opcode/func constants, ALU and jump encodings,
// and the per-stage control word carried down the pipeline.
package dlx_cu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_NOP   = 6'h15;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [10:0] FN_ADD = 11'h020;
  localparam logic [10:0] FN_SUB = 11'h022;
  localparam logic [10:0] FN_AND = 11'h024;
  localparam logic [10:0] FN_OR  = 11'h025;
  localparam logic [10:0] FN_XOR = 11'h026;

  typedef enum logic [2:0] {
    ALU_NOP = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    JMP_NONE   = 2'b00,
    JMP_BEQZ   = 2'b01,
    JMP_BNEZ   = 2'b10,
    JMP_UNCOND = 2'b11
  } jump_t;

  typedef struct packed {
    alu_op_t alu_op;
    logic    sel_imm;
    logic    dram_we;
    logic    read_mem;
    jump_t   jump_en;
    logic    rf_we;
    logic    wb_mux_sel;
    logic    illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/dlx_cu_pipe_if.sv
// Instruction-in / control-out bundle of the DLX control unit.
// STALL exists only when DLX_CU_STALL_EN is defined.
interface dlx_cu_pipe_if #(
  parameter int unsigned ALU_OP_W = 6
);
  logic [31:0]         IR_IN;
  logic                IR_VALID;
  logic                FLUSH;
`ifdef DLX_CU_STALL_EN
  logic                STALL;
`endif
  logic [ALU_OP_W-1:0] ALU_OPCODE;
  logic                SEL_IMM;
  logic                DRAM_WE;
  logic                READ_MEM;
  logic [1:0]          JUMP_EN;
  logic                RF_WE;
  logic                WB_MUX_SEL;
  logic                ILLEGAL;

  modport master (
`ifdef DLX_CU_STALL_EN
    output STALL,
`endif
    output IR_IN, IR_VALID, FLUSH,
    input  ALU_OPCODE, SEL_IMM, DRAM_WE, READ_MEM, JUMP_EN, RF_WE, WB_MUX_SEL, ILLEGAL
  );

  modport slave (
`ifdef DLX_CU_STALL_EN
    input  STALL,
`endif
    input  IR_IN, IR_VALID, FLUSH,
    output ALU_OPCODE, SEL_IMM, DRAM_WE, READ_MEM, JUMP_EN, RF_WE, WB_MUX_SEL, ILLEGAL
  );
endinterface

// File: rtl/dlx_cu_decode.sv
// Combinational DLX instruction decoder: instruction word -> control word.
module dlx_cu_decode
  import dlx_cu_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        valid,
  output ctrl_t       ctrl
);

  logic [5:0]  opcode;
  logic [10:0] func;
  logic        unused_ir;

  assign opcode    = ir[31:26];
  assign func      = ir[10:0];
  assign unused_ir = ^ir[25:11];

  always_comb begin
    ctrl = CTRL_BUBBLE;
    if (valid) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.rf_we = 1'b1;
          case (func)
            FN_ADD:  ctrl.alu_op = ALU_ADD;
            FN_SUB:  ctrl.alu_op = ALU_SUB;
            FN_AND:  ctrl.alu_op = ALU_AND;
            FN_OR:   ctrl.alu_op = ALU_OR;
            FN_XOR:  ctrl.alu_op = ALU_XOR;
            default: begin
              ctrl.rf_we   = 1'b0;
              ctrl.illegal = 1'b1;
            end
          endcase
        end
        OP_ADDI: begin ctrl.alu_op = ALU_ADD; ctrl.sel_imm = 1'b1; ctrl.rf_we = 1'b1; end
        OP_SUBI: begin ctrl.alu_op = ALU_SUB; ctrl.sel_imm = 1'b1; ctrl.rf_we = 1'b1; end
        OP_ANDI: begin ctrl.alu_op = ALU_AND; ctrl.sel_imm = 1'b1; ctrl.rf_we = 1'b1; end
        OP_ORI:  begin ctrl.alu_op = ALU_OR;  ctrl.sel_imm = 1'b1; ctrl.rf_we = 1'b1; end
        OP_XORI: begin ctrl.alu_op = ALU_XOR; ctrl.sel_imm = 1'b1; ctrl.rf_we = 1'b1; end
        OP_LW: begin
          ctrl.alu_op     = ALU_ADD;
          ctrl.sel_imm    = 1'b1;
          ctrl.read_mem   = 1'b1;
          ctrl.rf_we      = 1'b1;
          ctrl.wb_mux_sel = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_op  = ALU_ADD;
          ctrl.sel_imm = 1'b1;
          ctrl.dram_we = 1'b1;
        end
        OP_J:    ctrl.jump_en = JMP_UNCOND;
        OP_BEQZ: ctrl.jump_en = JMP_BEQZ;
        OP_BNEZ: ctrl.jump_en = JMP_BNEZ;
        OP_NOP:  ctrl = CTRL_BUBBLE;
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/dlx_cu_pipe.sv
// DLX control-unit pipeline: decoded control word shifted through WB_STAGE
// registers; EX/MEM/WB output groups tap fixed stages. Optional STALL via DLX_CU_STALL_EN.
module dlx_cu_pipe
  import dlx_cu_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 6,
  parameter int unsigned EX_STAGE = 3,
  parameter int unsigned WB_STAGE = EX_STAGE + 2
) (
  input  logic          Clk,
  input  logic          Rst,
  dlx_cu_pipe_if.slave  bus
);

  localparam int unsigned MEM_STAGE = EX_STAGE + 1;

  ctrl_t dec_word;
  ctrl_t stage_q [1:WB_STAGE];
  ctrl_t stage_d [1:WB_STAGE];
  logic  stall;

`ifdef DLX_CU_STALL_EN
  assign stall = bus.STALL;
`else
  assign stall = 1'b0;
`endif

  dlx_cu_decode u_decode (
    .ir    (bus.IR_IN),
    .valid (bus.IR_VALID),
    .ctrl  (dec_word)
  );

  // Per-stage next value resolved at elaboration: stages before EX hold on
  // stall, EX itself takes a bubble, later stages always advance.
  for (genvar k = 1; k <= WB_STAGE; k++) begin : g_next
    if (k == 1) begin : g_first
      if (EX_STAGE == 1) begin : g_is_ex
        assign stage_d[k] = (bus.FLUSH || stall) ? CTRL_BUBBLE : dec_word;
      end else begin : g_pre_ex
        assign stage_d[k] = bus.FLUSH ? CTRL_BUBBLE : (stall ? stage_q[k] : dec_word);
      end
    end else if (k < EX_STAGE) begin : g_hold
      assign stage_d[k] = stall ? stage_q[k] : stage_q[k-1];
    end else if (k == EX_STAGE) begin : g_ex
      assign stage_d[k] = stall ? CTRL_BUBBLE : stage_q[k-1];
    end else begin : g_adv
      assign stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      stage_q <= '{default: CTRL_BUBBLE};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.ALU_OPCODE = ALU_OP_W'(stage_q[EX_STAGE].alu_op);
  assign bus.SEL_IMM    = stage_q[EX_STAGE].sel_imm;
  assign bus.ILLEGAL    = stage_q[EX_STAGE].illegal;
  assign bus.DRAM_WE    = stage_q[MEM_STAGE].dram_we;
  assign bus.READ_MEM   = stage_q[MEM_STAGE].read_mem;
  assign bus.JUMP_EN    = stage_q[MEM_STAGE].jump_en;
  assign bus.RF_WE      = stage_q[WB_STAGE].rf_we;
  assign bus.WB_MUX_SEL = stage_q[WB_STAGE].wb_mux_sel;

endmodule

// File: tb/tb_dlx_cu_pipe.sv
// Bench for dlx_cu_pipe: a default-parameter instance and an EX_STAGE=1 instance
// driven with the same stimulus and checked against a behavioural model.
module tb_dlx_cu_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, stall, valid;
  logic [31:0] ir;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  dlx_cu_pipe_if #(.ALU_OP_W(6)) bus_a ();
  dlx_cu_pipe_if #(.ALU_OP_W(6)) bus_b ();

  assign bus_a.IR_IN    = ir;
  assign bus_a.IR_VALID = valid;
  assign bus_a.FLUSH    = flush;
  assign bus_b.IR_IN    = ir;
  assign bus_b.IR_VALID = valid;
  assign bus_b.FLUSH    = flush;
`ifdef DLX_CU_STALL_EN
  assign bus_a.STALL    = stall;
  assign bus_b.STALL    = stall;
`endif

  dlx_cu_pipe #(.ALU_OP_W(6), .EX_STAGE(3), .WB_STAGE(5)) dut_a (.Clk(clk), .Rst(rst), .bus(bus_a));
  dlx_cu_pipe #(.ALU_OP_W(6), .EX_STAGE(1), .WB_STAGE(2)) dut_b (.Clk(clk), .Rst(rst), .bus(bus_b));

  logic [13:0] obs_a, obs_b;
  assign obs_a = {bus_a.ALU_OPCODE, bus_a.SEL_IMM, bus_a.DRAM_WE, bus_a.READ_MEM,
                  bus_a.JUMP_EN, bus_a.RF_WE, bus_a.WB_MUX_SEL, bus_a.ILLEGAL};
  assign obs_b = {bus_b.ALU_OPCODE, bus_b.SEL_IMM, bus_b.DRAM_WE, bus_b.READ_MEM,
                  bus_b.JUMP_EN, bus_b.RF_WE, bus_b.WB_MUX_SEL, bus_b.ILLEGAL};

  typedef struct {
    int alu;
    int jmp;
    bit imm;
    bit we;
    bit rd;
    bit rf;
    bit wbm;
    bit ill;
  } mword_t;

  // pm[d][k]: instruction effect held at stage k of instance d (0 = default, 1 = EX_STAGE=1)
  mword_t pm [2][7];

  int unsigned op_tab [14] = '{'h00, 'h00, 'h02, 'h04, 'h05, 'h08, 'h0A,
                               'h0C, 'h0D, 'h0E, 'h15, 'h23, 'h2B, 'h3F};
  int unsigned fn_tab [7]  = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h21, 'h7FF};

  function automatic mword_t ref_dec(logic [31:0] w, logic v);
    mword_t m = '{default: 0};
    int op = int'(w[31:26]);
    int fn = int'(w[10:0]);
    if (!v) return m;
    if (op == 'h00) begin
      case (fn)
        'h20: m.alu = 1;
        'h22: m.alu = 2;
        'h24: m.alu = 3;
        'h25: m.alu = 4;
        'h26: m.alu = 5;
        default: m.ill = 1;
      endcase
      m.rf = !m.ill;
    end else if (op == 'h08 || op == 'h0A || op == 'h0C || op == 'h0D || op == 'h0E) begin
      m.alu = (op == 'h08) ? 1 : (op == 'h0A) ? 2 : (op == 'h0C) ? 3 : (op == 'h0D) ? 4 : 5;
      m.imm = 1;
      m.rf  = 1;
    end else if (op == 'h23) begin
      m.alu = 1; m.imm = 1; m.rd = 1; m.rf = 1; m.wbm = 1;
    end else if (op == 'h2B) begin
      m.alu = 1; m.imm = 1; m.we = 1;
    end else if (op == 'h02) m.jmp = 3;
    else if (op == 'h04) m.jmp = 1;
    else if (op == 'h05) m.jmp = 2;
    else if (op != 'h15) m.ill = 1;
    return m;
  endfunction

  function automatic logic [13:0] exp_out(int d);
    int ex = (d == 0) ? 3 : 1;
    int wb = (d == 0) ? 5 : 2;
    mword_t x = pm[d][ex];
    mword_t y = pm[d][ex+1];
    mword_t z = pm[d][wb];
    return {6'(x.alu), x.imm, y.we, y.rd, 2'(y.jmp), z.rf, z.wbm, x.ill};
  endfunction

  task automatic model_edge();
    mword_t din, src;
    mword_t nxt [7];
    mword_t zero = '{default: 0};
    bit     st;
    int     ex, wb;
    din = ref_dec(ir, valid);
`ifdef DLX_CU_STALL_EN
    st = stall;
`else
    st = 0;
`endif
    for (int d = 0; d < 2; d++) begin
      ex = (d == 0) ? 3 : 1;
      wb = (d == 0) ? 5 : 2;
      for (int k = 1; k <= wb; k++) begin
        src = (k == 1) ? din : pm[d][k-1];
        if (rst)                 nxt[k] = zero;
        else if (k == 1 && flush) nxt[k] = zero;
        else if (st && k == ex)   nxt[k] = zero;
        else if (st && k < ex)    nxt[k] = pm[d][k];
        else                      nxt[k] = src;
      end
      for (int k = 1; k <= wb; k++) pm[d][k] = nxt[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    rst = 0; flush = 0; stall = 0; valid = 0; ir = $urandom;
  endtask

  task automatic do_reset();
    rst = 1; flush = 0; stall = 0; valid = 0; ir = $urandom;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1; flush = 1; stall = 1; valid = 1; ir = 32'h00221820;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (obs_a !== 14'h0) begin
        miscompares++;
        $display("FAIL reset_a: got %h expected %h", obs_a, 14'h0);
      end
      vectors++;
      if (obs_b !== 14'h0) begin
        miscompares++;
        $display("FAIL reset_b: got %h expected %h", obs_b, 14'h0);
      end
    end
    idle();
  endtask

  task automatic test_add();
    do_reset();
    ir = 32'h00221820; valid = 1;
    step();
    vectors++;
    if (bus_b.ALU_OPCODE !== 6'd1) begin
      miscompares++;
      $display("FAIL add_ex1_latency: got %0d expected 1", bus_b.ALU_OPCODE);
    end
    idle();
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd0) begin
      miscompares++;
      $display("FAIL add_early: got %0d expected 0", bus_a.ALU_OPCODE);
    end
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd1 || bus_a.SEL_IMM !== 1'b0) begin
      miscompares++;
      $display("FAIL add_ex: got alu=%0d imm=%b expected alu=1 imm=0", bus_a.ALU_OPCODE, bus_a.SEL_IMM);
    end
    step();
    step();
    vectors++;
    if (bus_a.RF_WE !== 1'b1 || bus_a.WB_MUX_SEL !== 1'b0) begin
      miscompares++;
      $display("FAIL add_wb: got rf_we=%b wb_sel=%b expected 1 0", bus_a.RF_WE, bus_a.WB_MUX_SEL);
    end
  endtask

  task automatic test_lw();
    do_reset();
    ir = 32'h8C220004; valid = 1;
    step();
    idle();
    step();
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd1 || bus_a.SEL_IMM !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_ex: got alu=%0d imm=%b expected alu=1 imm=1", bus_a.ALU_OPCODE, bus_a.SEL_IMM);
    end
    step();
    vectors++;
    if (bus_a.READ_MEM !== 1'b1 || bus_a.DRAM_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_mem: got rd=%b we=%b expected rd=1 we=0", bus_a.READ_MEM, bus_a.DRAM_WE);
    end
    step();
    vectors++;
    if (bus_a.RF_WE !== 1'b1 || bus_a.WB_MUX_SEL !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_wb: got rf_we=%b wb_sel=%b expected 1 1", bus_a.RF_WE, bus_a.WB_MUX_SEL);
    end
  endtask

  task automatic test_flush();
    do_reset();
    ir = 32'h14400008; valid = 1;
    step();
    ir = 32'h00221820; valid = 1; flush = 1;
    step();
    idle();
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd0 || bus_a.JUMP_EN !== 2'b00) begin
      miscompares++;
      $display("FAIL flush_c3: got alu=%0d jmp=%b expected 0 00", bus_a.ALU_OPCODE, bus_a.JUMP_EN);
    end
    step();
    vectors++;
    if (bus_a.JUMP_EN !== 2'b10 || bus_a.ALU_OPCODE !== 6'd0) begin
      miscompares++;
      $display("FAIL flush_bnez: got jmp=%b alu=%0d expected 10 0", bus_a.JUMP_EN, bus_a.ALU_OPCODE);
    end
    for (int c = 5; c <= 6; c++) begin
      step();
      vectors++;
      if (obs_a !== 14'h0) begin
        miscompares++;
        $display("FAIL flush_squashed_c%0d: got %h expected %h", c, obs_a, 14'h0);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ir = 32'hFC000000; valid = 1;
    step();
    vectors++;
    if (obs_b !== 14'h0001) begin
      miscompares++;
      $display("FAIL illegal_ex1: got %h expected %h", obs_b, 14'h0001);
    end
    idle();
    step();
    step();
    vectors++;
    if (obs_a !== 14'h0001) begin
      miscompares++;
      $display("FAIL illegal_c3: got %h expected %h", obs_a, 14'h0001);
    end
    step();
    vectors++;
    if (bus_a.ILLEGAL !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_pulse: got %b expected 0", bus_a.ILLEGAL);
    end
  endtask

`ifdef DLX_CU_STALL_EN
  task automatic test_stall();
    do_reset();
    ir = 32'h00221820; valid = 1;
    step();
    ir = 32'h00221822; valid = 1;
    step();
    idle();
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd1) begin
      miscompares++;
      $display("FAIL stall_add: got %0d expected 1", bus_a.ALU_OPCODE);
    end
    stall = 1; valid = 1; ir = 32'h00221824;
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd0) begin
      miscompares++;
      $display("FAIL stall_bubble: got %0d expected 0", bus_a.ALU_OPCODE);
    end
    idle();
    step();
    vectors++;
    if (bus_a.ALU_OPCODE !== 6'd2) begin
      miscompares++;
      $display("FAIL stall_sub: got %0d expected 2", bus_a.ALU_OPCODE);
    end
  endtask
`endif

  task automatic test_reset_midstream();
    do_reset();
    valid = 1;
    ir = 32'h00221820; step();
    ir = 32'h8C220004; step();
    ir = 32'hAC220004; step();
    rst = 1; flush = 1; stall = 1; valid = 1; ir = 32'h00221822;
    step();
    idle();
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (obs_a !== 14'h0) begin
        miscompares++;
        $display("FAIL midreset_a_%0d: got %h expected %h", c, obs_a, 14'h0);
      end
      vectors++;
      if (obs_b !== 14'h0) begin
        miscompares++;
        $display("FAIL midreset_b_%0d: got %h expected %h", c, obs_b, 14'h0);
      end
      step();
    end
    ir = 32'h00221826; valid = 1;
    step();
    vectors++;
    if (bus_b.ALU_OPCODE !== 6'd5) begin
      miscompares++;
      $display("FAIL midreset_ex1_latency: got %0d expected 5", bus_b.ALU_OPCODE);
    end
    idle();
  endtask

  task automatic test_random();
    logic [13:0] e;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 5) == 0);
      valid = ($urandom_range(0, 3) != 0);
      ir    = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        ir[31:26] = 6'(op_tab[$urandom_range(0, 13)]);
        if (ir[31:26] == 6'h00) ir[10:0] = 11'(fn_tab[$urandom_range(0, 6)]);
      end
      step();
      e = exp_out(0);
      vectors++;
      if (obs_a !== e) begin
        miscompares++;
        $display("FAIL random_a cyc %0d: got %h expected %h", i, obs_a, e);
      end
      e = exp_out(1);
      vectors++;
      if (obs_b !== e) begin
        miscompares++;
        $display("FAIL random_b cyc %0d: got %h expected %h", i, obs_b, e);
      end
    end
    idle();
  endtask

  initial begin
    rst = 1; flush = 0; stall = 0; valid = 0; ir = '0;
    test_reset();
    test_add();
    test_lw();
    test_flush();
    test_illegal();
`ifdef DLX_CU_STALL_EN
    test_stall();
`endif
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
